// File: rtl/opend_barrier_ctrl_if.sv
// Handshake bundle between the barrier sequencer, the cores and the memory controller.
// master is the sequencer side; slave is the side of the cores, the host and the memory controller.
interface opend_barrier_ctrl_if #(
   parameter int NUM_CORES = 16,
   parameter int ITER_W    = 8,
   parameter int TO_W      = 12
);
   logic                 start;
   logic [NUM_CORES-1:0] core_mask;
   logic [ITER_W-1:0]    num_iters;
   logic [TO_W-1:0]      timeout;
   logic [NUM_CORES-1:0] core_done;
   logic                 mem_ack;
   logic [NUM_CORES-1:0] core_go;
   logic                 mem_req;
   logic [NUM_CORES-1:0] done_flags;
   logic [ITER_W-1:0]    iter_count;
   logic                 busy;
   logic                 finished;
   logic                 timed_out;

   modport master (
      input  start, core_mask, num_iters, timeout, core_done, mem_ack,
      output core_go, mem_req, done_flags, iter_count, busy, finished, timed_out
   );

   modport slave (
      output start, core_mask, num_iters, timeout, core_done, mem_ack,
      input  core_go, mem_req, done_flags, iter_count, busy, finished, timed_out
   );
endinterface

// File: rtl/opend_barrier_ctrl.sv
// Barrier sequencer: releases the participating cores, gathers their op-end flags and
// issues one memory transfer per iteration, with a wait-phase timeout against hung cores.
module opend_barrier_ctrl #(
   parameter int NUM_CORES = 16,
   parameter int ITER_W    = 8,
   parameter int TO_W      = 12
) (
   input  logic                    clk,
   input  logic                    reset_n,
   opend_barrier_ctrl_if.master    bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RELEASE = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_MEM     = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]           state;
   logic [NUM_CORES-1:0] mask_q;
   logic [NUM_CORES-1:0] flags_q;
   logic [NUM_CORES-1:0] nxt_flags;
   logic [ITER_W-1:0]    iters_q;
   logic [ITER_W-1:0]    iter_q;
   logic [ITER_W-1:0]    iter_inc;
   logic [TO_W-1:0]      tmo_q;
   logic [TO_W-1:0]      to_cnt;
   logic [TO_W-1:0]      to_inc;
   logic                 to_q;
   logic                 all_done;
   logic                 expired;

   // A flag arriving in the same WAIT cycle already counts towards completion.
   always_comb begin
      nxt_flags = flags_q | (bus.core_done & mask_q);
      all_done  = (nxt_flags == mask_q);
      to_inc    = to_cnt + TO_W'(1);
      expired   = (tmo_q != '0) && (to_inc == tmo_q);
      iter_inc  = iter_q + ITER_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         mask_q  <= '0;
         flags_q <= '0;
         iters_q <= '0;
         iter_q  <= '0;
         tmo_q   <= '0;
         to_cnt  <= '0;
         to_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  mask_q  <= bus.core_mask;
                  iters_q <= bus.num_iters;
                  tmo_q   <= bus.timeout;
                  iter_q  <= '0;
                  to_q    <= 1'b0;
                  state   <= (bus.core_mask == '0 || bus.num_iters == '0) ? S_DONE : S_RELEASE;
               end
            end
            S_RELEASE: begin
               flags_q <= '0;
               to_cnt  <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               flags_q <= nxt_flags;
               to_cnt  <= to_inc;
               if (all_done) begin
                  state <= S_MEM;
               end else if (expired) begin
                  to_q  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_MEM: begin
               if (bus.mem_ack) begin
                  iter_q <= iter_inc;
                  state  <= (iter_inc == iters_q) ? S_DONE : S_RELEASE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode straight from state, so reset drops mem_req without waiting for an edge.
   assign bus.core_go    = (state == S_RELEASE) ? mask_q : '0;
   assign bus.mem_req    = (state == S_MEM);
   assign bus.done_flags = flags_q;
   assign bus.iter_count = iter_q;
   assign bus.busy       = (state != S_IDLE);
   assign bus.finished   = (state == S_DONE);
   assign bus.timed_out  = to_q;
endmodule
